float_compare_arbiter: RTL and testbench
========================================

Name: float_compare_arbiter

Overview:
Shares one pipelined single-precision float comparator between N_REQ independent requesters in the control-system datapath, for example the limiter, hysteresis and protection-threshold checks.
- Each requester pulses a start with two operands.
- The arbiter queues one request per requester and issues queued requests to the comparator round-robin, one per cycle.
- It tracks in-flight requests with a tag pipeline and returns agb/alb plus a done pulse to the owning requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand width (`SINGLE)
CMP_LAT, 1, comparator clock latency from cmp_a/cmp_b valid to cmp_agb/cmp_alb valid (1..4)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  asynchronous, active-high reset
req_sta  in  N_REQ  per-requester start pulse (one cycle)
req_a  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B; same packing as req_a
res_agb  out  N_REQ  per-requester result A>B, held until that requester's next done
res_alb  out  N_REQ  per-requester result A<B, held until that requester's next done
res_done  out  N_REQ  one-cycle pulse per requester when its result updates
req_ovf  out  N_REQ  sticky flag: a start was dropped
cmp_a  out  WIDTH  operand A to the comparator (dataa)
cmp_b  out  WIDTH  operand B to the comparator (datab)
cmp_vld  out  1  high when cmp_a/cmp_b carry an issued request
cmp_agb  in  1  comparator agb output
cmp_alb  in  1  comparator alb output
busy  out  1  OR of all pending bits and all in-flight tags

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - All outputs go to 0: res_*, res_done, req_ovf, cmp_a, cmp_b, cmp_vld, busy.
  - Pending bits, operand registers and the tag pipeline clear; the round-robin pointer returns to 0.
  - In-flight requests are discarded and produce no done.
- Capture:
  - If req_sta[i] is high and pending[i]=0, operands for i are latched and pending[i] is set.
  - If pending[i]=1 and i is not granted this cycle, the start is dropped: operands are unchanged and req_ovf[i] sets.
  - If i is granted in the same cycle, the new request is accepted: pending[i] stays set with the new operands.
- Arbitration (each cycle):
  - Grant the first pending requester at or after pointer ptr, searching upward modulo N_REQ.
  - On a grant to g: ptr <= (g+1) mod N_REQ, and pending[g] clears unless re-captured.
  - With no pending requester, ptr holds and there is no grant.
- Issue (registered):
  - At the edge after a grant: cmp_a/cmp_b take the operands of g, cmp_vld=1, and tag {valid=1, id=g} enters stage 0.
  - Otherwise cmp_vld=0 and cmp_a/cmp_b hold their values.
- Tag pipeline:
  - CMP_LAT stages, shifting every cycle with no stall.
  - When the last stage is valid with id k: at the next edge, res_agb[k]<=cmp_agb, res_alb[k]<=cmp_alb, and res_done[k] pulses for one cycle.
- Latency:
  - Uncontended: req_sta in cycle 0 gives res_done in cycle 3+CMP_LAT (cycle 4 when CMP_LAT=1).
  - Throughput is one comparison per cycle.
- Results:
  - Equal operands give agb=alb=0.
  - NaN and other results pass through from the comparator unmodified; the arbiter does not interpret them.
- Other rules:
  - Multiple res_done bits are never high in the same cycle.
  - req_ovf clears only on reset.
  - busy=0 guarantees no result is outstanding.

Test Plan:
1. Single request: req_sta[0] with A=0x40400000 (3.0), B=0x3F800000 (1.0) -> cmp_vld in cycle 2; res_done[0] in cycle 4 with res_agb[0]=1, res_alb[0]=0; busy low from cycle 5.
2. All four requesters start simultaneously with ptr=0, using pairs (1,2), (2,1), (5,5), (-1,0) -> issue order 0,1,2,3 on consecutive cycles; results in that order are alb, agb, neither, alb; ptr ends at 0.
3. Fairness: requester 0 re-pulses immediately after each grant while requester 2 is continuously pending -> grants alternate 0,2,0,2; no starvation; req_ovf stays 0.
4. Overflow: pulse req_sta[1] twice, 1 cycle apart, while requesters 0 and 1 are both pending -> req_ovf[1]=1 and the first operands are compared. In a separate case, a start in the same cycle as requester 1's grant is accepted with req_ovf unchanged.
5. Reset mid-operation: assert rst while 2 tags are in flight and 1 request is pending -> no res_done after release; all outputs 0; the next request completes with nominal latency.
6. CMP_LAT=3 build with a comparator model -> 5 back-to-back requests from mixed requesters each return correct agb/alb to the right id at cycle 6 after their start when uncontended.

Source files
------------

// File: rtl/float_compare_arbiter.sv
// Round-robin arbiter sharing one pipelined float comparator among N_REQ requesters.
// Each requester owns one queued slot; results return through a tag pipeline matched to CMP_LAT.
module float_compare_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_sta,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       res_agb,
  output logic [N_REQ-1:0]       res_alb,
  output logic [N_REQ-1:0]       res_done,
  output logic [N_REQ-1:0]       req_ovf,
  output logic [WIDTH-1:0]       cmp_a,
  output logic [WIDTH-1:0]       cmp_b,
  output logic                   cmp_vld,
  input  logic                   cmp_agb,
  input  logic                   cmp_alb,
  output logic                   busy
);

  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] pending_q, pending_d, accept;
  logic [WIDTH-1:0] opa_q [N_REQ];
  logic [WIDTH-1:0] opb_q [N_REQ];
  logic [IdW-1:0]   ptr_q;
  logic             gnt_vld;
  logic [IdW-1:0]   gnt_id;
  logic             busy_d;

  // Stage 0 is aligned with cmp_a/cmp_b; stage CMP_LAT with the comparator result.
  logic [CMP_LAT:0] tag_vld_q;
  logic [IdW-1:0]   tag_id_q [CMP_LAT+1];

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!gnt_vld && pending_q[idx[IdW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[IdW-1:0];
      end
    end
  end

  // A start is accepted into a free slot, or into the slot being granted this cycle.
  always_comb begin
    accept    = '0;
    pending_d = pending_q;
    if (gnt_vld) pending_d[gnt_id] = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      accept[i] = req_sta[i] && (!pending_q[i] || (gnt_vld && 32'(gnt_id) == i));
    end
    pending_d = pending_d | accept;
    busy_d    = (|pending_d) || gnt_vld || (|tag_vld_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ptr_q     <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_vld   <= 1'b0;
      tag_vld_q <= '0;
      res_agb   <= '0;
      res_alb   <= '0;
      res_done  <= '0;
      req_ovf   <= '0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
      for (int unsigned s = 0; s <= CMP_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          opa_q[i] <= req_a[i*WIDTH +: WIDTH];
          opb_q[i] <= req_b[i*WIDTH +: WIDTH];
        end
      end
      if (gnt_vld) begin
        ptr_q <= (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + IdW'(1);
        cmp_a <= opa_q[gnt_id];
        cmp_b <= opb_q[gnt_id];
      end
      cmp_vld     <= gnt_vld;
      tag_vld_q   <= {tag_vld_q[CMP_LAT-1:0], gnt_vld};
      tag_id_q[0] <= gnt_id;
      for (int unsigned s = 1; s <= CMP_LAT; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
      res_done <= '0;
      if (tag_vld_q[CMP_LAT]) begin
        res_done[tag_id_q[CMP_LAT]] <= 1'b1;
        res_agb[tag_id_q[CMP_LAT]]  <= cmp_agb;
        res_alb[tag_id_q[CMP_LAT]]  <= cmp_alb;
      end
      req_ovf <= req_ovf | (req_sta & ~accept);
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_float_compare_arbiter.sv
// Bench for float_compare_arbiter: CMP_LAT=1 and CMP_LAT=3 instances share stimulus and
// are scored each cycle against a queue-based model of the arbiter.
module tb_float_compare_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    int         due;
    int         id;
    logic [1:0] r;
  } fl_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_sta = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;

  logic [N-1:0] agb1, alb1, done1, ovf1, agb3, alb3, done3, ovf3;
  logic [W-1:0] ca1, cb1, ca3, cb3;
  logic         cv1, cv3, busy1, busy3;
  logic [1:0]   cpipe1;
  logic [1:0]   cpipe3 [3];

  int total = 0;
  int bad   = 0;

  // Model state
  logic [N-1:0] m_pend, m_ovf;
  logic [W-1:0] m_a [N];
  logic [W-1:0] m_b [N];
  int           m_ptr, edge_n;
  fl_t          q1[$];
  fl_t          q3[$];
  logic [N-1:0] e_done1, e_agb1, e_alb1, e_done3, e_agb3, e_alb3;
  logic         e_busy1, e_busy3;

  always #5 clk = ~clk;

  float_compare_arbiter #(.N_REQ(N), .WIDTH(W), .CMP_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_sta(req_sta), .req_a(req_a), .req_b(req_b),
    .res_agb(agb1), .res_alb(alb1), .res_done(done1), .req_ovf(ovf1),
    .cmp_a(ca1), .cmp_b(cb1), .cmp_vld(cv1),
    .cmp_agb(cpipe1[1]), .cmp_alb(cpipe1[0]), .busy(busy1)
  );

  float_compare_arbiter #(.N_REQ(N), .WIDTH(W), .CMP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_sta(req_sta), .req_a(req_a), .req_b(req_b),
    .res_agb(agb3), .res_alb(alb3), .res_done(done3), .req_ovf(ovf3),
    .cmp_a(ca3), .cmp_b(cb3), .cmp_vld(cv3),
    .cmp_agb(cpipe3[2][1]), .cmp_alb(cpipe3[2][0]), .busy(busy3)
  );

  // IEEE single compare: {a>b, a<b}; NaN operands give neither, +0 equals -0.
  function automatic logic [1:0] fcmp(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 2'b00;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    return {ka > kb, ka < kb};
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [31:0] f;
    f = {$urandom_range(1, 0) == 1, 8'(120 + $urandom_range(15, 0)), 23'($urandom)};
    return f;
  endfunction

  always @(posedge clk) begin
    cpipe1    <= fcmp(ca1, cb1);
    cpipe3[0] <= fcmp(ca3, cb3);
    cpipe3[1] <= cpipe3[0];
    cpipe3[2] <= cpipe3[1];
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic model_clear();
    m_pend = '0; m_ovf = '0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin m_a[i] = '0; m_b[i] = '0; end
    q1.delete(); q3.delete();
    e_done1 = '0; e_agb1 = '0; e_alb1 = '0; e_busy1 = 1'b0;
    e_done3 = '0; e_agb3 = '0; e_alb3 = '0; e_busy3 = 1'b0;
  endtask

  // Drive one cycle of starts and advance the model across the following edge.
  task automatic cycle(input logic [N-1:0] sta);
    int  g;
    fl_t f;
    req_sta = sta;
    @(posedge clk);
    edge_n++;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) begin
      f.id = g; f.r = fcmp(m_a[g], m_b[g]);
      f.due = edge_n + 2; q1.push_back(f);
      f.due = edge_n + 4; q3.push_back(f);
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (sta[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1; m_a[i] = req_a[i*W +: W]; m_b[i] = req_b[i*W +: W];
        end else m_ovf[i] = 1'b1;
      end
    end
    e_busy1 = (m_pend != 0) || (q1.size() != 0);
    e_busy3 = (m_pend != 0) || (q3.size() != 0);
    e_done1 = '0; e_done3 = '0;
    while (q1.size() != 0 && q1[0].due == edge_n) begin
      f = q1.pop_front(); e_done1[f.id] = 1'b1; e_agb1[f.id] = f.r[1]; e_alb1[f.id] = f.r[0];
    end
    while (q3.size() != 0 && q3[0].due == edge_n) begin
      f = q3.pop_front(); e_done3[f.id] = 1'b1; e_agb3[f.id] = f.r[1]; e_alb3[f.id] = f.r[0];
    end
    @(negedge clk);
  endtask

  task automatic assert_rst();
    rst = 1'b1; req_sta = '0;
    model_clear();
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Per-cycle scoreboard against the model for both instances.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      total++;
      if ({done1, agb1, alb1, ovf1, busy1} !== {e_done1, e_agb1, e_alb1, m_ovf, e_busy1}) begin
        bad++;
        $display("FAIL score_lat1 t=%0t got done=%b agb=%b alb=%b ovf=%b busy=%b want %b %b %b %b %b",
                 $time, done1, agb1, alb1, ovf1, busy1, e_done1, e_agb1, e_alb1, m_ovf, e_busy1);
      end
      total++;
      if ({done3, agb3, alb3, ovf3, busy3} !== {e_done3, e_agb3, e_alb3, m_ovf, e_busy3}) begin
        bad++;
        $display("FAIL score_lat3 t=%0t got done=%b agb=%b alb=%b ovf=%b busy=%b want %b %b %b %b %b",
                 $time, done3, agb3, alb3, ovf3, busy3, e_done3, e_agb3, e_alb3, m_ovf, e_busy3);
      end
      total++;
      if ($countones(done1) > 1 || $countones(done3) > 1) begin
        bad++;
        $display("FAIL done_onehot got %b / %b want at most one bit", done1, done3);
      end
    end
  end

  task automatic test_reset();
    assert_rst();
    set_op(0, 32'h40400000, 32'h3F800000);
    cycle(4'b0001);
    #1;
    total++;
    if ({agb1, alb1, done1, ovf1, ca1, cb1, cv1, busy1, agb3, alb3, done3, ovf3, ca3, cb3, cv3,
         busy3} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b/%b cmp_vld=%b/%b want all zero", busy1, busy3,
               cv1, cv3);
    end
    release_rst();
  endtask

  // 3.0 vs 1.0 from requester 0, uncontended
  task automatic test_single();
    assert_rst(); release_rst();
    set_op(0, 32'h40400000, 32'h3F800000);
    cycle(4'b0001);
    for (int c = 1; c <= 7; c++) begin
      total++;
      if (cv1 !== (c == 2) || (c == 2 && (ca1 !== 32'h40400000 || cb1 !== 32'h3F800000))) begin
        bad++; $display("FAIL single_issue cycle=%0d got vld=%b a=%h want vld=%b", c, cv1, ca1, c == 2);
      end
      total++;
      if (done1[0] !== (c == 4) || done3[0] !== (c == 6)) begin
        bad++; $display("FAIL single_done cycle=%0d got %b/%b want %b/%b", c, done1[0], done3[0],
                        c == 4, c == 6);
      end
      total++;
      if (busy1 !== (c <= 4)) begin
        bad++; $display("FAIL single_busy cycle=%0d got %b want %b", c, busy1, c <= 4);
      end
      cycle(4'b0000);
    end
    total++;
    if (agb1[0] !== 1'b1 || alb1[0] !== 1'b0) begin
      bad++; $display("FAIL single_result got agb=%b alb=%b want agb=1 alb=0", agb1[0], alb1[0]);
    end
  endtask

  task automatic test_all4();
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    ea[0] = 32'h3F800000; eb[0] = 32'h40000000;  // 1 vs 2
    ea[1] = 32'h40000000; eb[1] = 32'h3F800000;  // 2 vs 1
    ea[2] = 32'h40A00000; eb[2] = 32'h40A00000;  // 5 vs 5
    ea[3] = 32'hBF800000; eb[3] = 32'h00000000;  // -1 vs 0
    assert_rst(); release_rst();
    for (int i = 0; i < 4; i++) set_op(i, ea[i], eb[i]);
    cycle(4'b1111);
    for (int c = 1; c <= 8; c++) begin
      if (c >= 2 && c <= 5) begin
        total++;
        if (cv1 !== 1'b1 || ca1 !== ea[c-2] || cb1 !== eb[c-2]) begin
          bad++; $display("FAIL all4_order cycle=%0d got vld=%b a=%h b=%h want a=%h b=%h", c, cv1,
                          ca1, cb1, ea[c-2], eb[c-2]);
        end
      end
      if (c >= 4 && c <= 7) begin
        total++;
        if (done1 !== 4'(1 << (c - 4))) begin
          bad++; $display("FAIL all4_done cycle=%0d got %b want %b", c, done1, 4'(1 << (c - 4)));
        end
      end
      cycle(4'b0000);
    end
    total++;
    if (agb1 !== 4'b0010 || alb1 !== 4'b1001) begin
      bad++; $display("FAIL all4_results got agb=%b alb=%b want agb=0010 alb=1001", agb1, alb1);
    end
    // Pointer should be back at 0: requester 0 wins over 3.
    set_op(3, 32'h41000000, 32'h0); set_op(0, 32'h41100000, 32'h0);
    cycle(4'b1001); cycle(4'b0000);
    total++;
    if (ca1 !== 32'h41100000) begin
      bad++; $display("FAIL all4_ptr got a=%h want %h", ca1, 32'h41100000);
    end
    repeat (6) cycle(4'b0000);
  endtask

  task automatic test_fairness();
    logic [31:0] cur [N];
    logic [31:0] nxt;
    logic [31:0] exp_a;
    int          gid;
    assert_rst(); release_rst();
    cur[0] = rnd_float(); cur[2] = rnd_float();
    set_op(0, cur[0], 32'h0); set_op(2, cur[2], 32'h0);
    cycle(4'b0101);
    exp_a = '0;
    for (int c = 1; c <= 9; c++) begin
      if (c >= 2) begin
        total++;
        if (cv1 !== 1'b1 || ca1 !== exp_a) begin
          bad++; $display("FAIL fair_alternate cycle=%0d got vld=%b a=%h want a=%h", c, cv1, ca1,
                          exp_a);
        end
      end
      gid = (c % 2 == 1) ? 0 : 2;
      exp_a = cur[gid];
      nxt = rnd_float(); cur[gid] = nxt;
      set_op(gid, nxt, 32'h0);
      cycle(4'(1 << gid));
    end
    total++;
    if (ovf1 !== 4'b0000) begin
      bad++; $display("FAIL fair_ovf got %b want 0000", ovf1);
    end
    repeat (8) cycle(4'b0000);
  endtask

  task automatic test_overflow();
    assert_rst(); release_rst();
    set_op(0, 32'h40000000, 32'h3F800000); set_op(1, 32'h40400000, 32'h40800000);
    cycle(4'b0011);
    set_op(1, 32'h41200000, 32'h41300000);
    cycle(4'b0010);
    total++;
    if (ovf1 !== 4'b0010) begin
      bad++; $display("FAIL ovf_drop_flag got %b want 0010", ovf1);
    end
    cycle(4'b0000);
    total++;
    if (ca1 !== 32'h40400000 || cb1 !== 32'h40800000) begin
      bad++; $display("FAIL ovf_first_kept got a=%h b=%h want 40400000 40800000", ca1, cb1);
    end
    repeat (6) cycle(4'b0000);
    // Start coinciding with the grant of requester 1 is accepted.
    assert_rst(); release_rst();
    set_op(0, 32'h40000000, 32'h3F800000); set_op(1, 32'h40400000, 32'h40800000);
    cycle(4'b0011); cycle(4'b0000);
    set_op(1, 32'h41200000, 32'h41300000);
    cycle(4'b0010);
    total++;
    if (ca1 !== 32'h40400000) begin
      bad++; $display("FAIL ovf_grant_issue got a=%h want 40400000", ca1);
    end
    cycle(4'b0000);
    total++;
    if (cv1 !== 1'b1 || ca1 !== 32'h41200000 || ovf1 !== 4'b0000) begin
      bad++; $display("FAIL ovf_same_cycle got vld=%b a=%h ovf=%b want 1 41200000 0000", cv1, ca1,
                      ovf1);
    end
    repeat (6) cycle(4'b0000);
  endtask

  task automatic test_reset_mid();
    assert_rst(); release_rst();
    for (int i = 0; i < 3; i++) set_op(i, rnd_float(), rnd_float());
    cycle(4'b0111); cycle(4'b0000); cycle(4'b0000);
    assert_rst();
    #1;
    total++;
    if ({agb1, alb1, done1, ovf1, ca1, cb1, cv1, busy1, done3, busy3} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got busy=%b done=%b vld=%b want all zero", busy1, done1,
                      cv1);
    end
    release_rst();
    for (int c = 0; c < 6; c++) begin
      total++;
      if (done1 !== '0 || done3 !== '0 || busy1 !== 1'b0) begin
        bad++; $display("FAIL rstmid_quiet cycle=%0d got done=%b/%b busy=%b want 0", c, done1,
                        done3, busy1);
      end
      cycle(4'b0000);
    end
    set_op(2, 32'hC0000000, 32'h3F800000);
    cycle(4'b0100);
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (done1[2] !== (c == 4)) begin
        bad++; $display("FAIL rstmid_next cycle=%0d got %b want %b", c, done1[2], c == 4);
      end
      cycle(4'b0000);
    end
    total++;
    if (alb1[2] !== 1'b1 || agb1[2] !== 1'b0) begin
      bad++; $display("FAIL rstmid_result got agb=%b alb=%b want 0 1", agb1[2], alb1[2]);
    end
  endtask

  task automatic test_back_to_back();
    int          ids [5];
    logic [1:0]  er  [5];
    logic [31:0] a, b;
    int          j;
    ids[0] = 1; ids[1] = 3; ids[2] = 0; ids[3] = 2; ids[4] = 1;
    assert_rst(); release_rst();
    for (int s = 0; s < 12; s++) begin
      if (s < 5) begin
        a = rnd_float();
        b = ($urandom_range(3, 0) == 0) ? a : rnd_float();
        er[s] = fcmp(a, b);
        set_op(ids[s], a, b);
        cycle(4'(1 << ids[s]));
      end else cycle(4'b0000);
      j = s + 1 - 6;
      if (j >= 0 && j < 5) begin
        total++;
        if (done3 !== 4'(1 << ids[j]) || {agb3[ids[j]], alb3[ids[j]]} !== er[j]) begin
          bad++; $display("FAIL b2b_lat3 req=%0d got done=%b res=%b%b want done=%b res=%b", j,
                          done3, agb3[ids[j]], alb3[ids[j]], 4'(1 << ids[j]), er[j]);
        end
      end
      j = s + 1 - 4;
      if (j >= 0 && j < 5) begin
        total++;
        if (done1 !== 4'(1 << ids[j]) || {agb1[ids[j]], alb1[ids[j]]} !== er[j]) begin
          bad++; $display("FAIL b2b_lat1 req=%0d got done=%b res=%b%b want done=%b res=%b", j,
                          done1, agb1[ids[j]], alb1[ids[j]], 4'(1 << ids[j]), er[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    assert_rst(); release_rst();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        a = ($urandom_range(15, 0) == 0) ? 32'h7FC00000 : rnd_float();
        b = ($urandom_range(4, 0) == 0) ? a : rnd_float();
        set_op(i, a, b);
      end
      cycle(4'($urandom) & 4'($urandom));
    end
    repeat (12) cycle(4'b0000);
    total++;
    if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
      bad++; $display("FAIL random_drain got busy=%b/%b want 0/0", busy1, busy3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    edge_n = 0;
    model_clear();
    test_reset();
    test_single();
    test_all4();
    test_fairness();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
